instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, byte address width; matches the instruction RAM port.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width; multiple of 8.
REQ-003 Parameter FIFO_DEPTH, default 2, prefetch entries; power of two, at least 2.
REQ-004 Parameter BOOT_ADDR, default 0, first fetch address after reset; word-aligned.
REQ-005 Clocking: one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-006 clk_i  in  1  clock; all state updates on the rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 fetch_en_i  in  1  enables issuing new fetches.
REQ-009 ram_addr_o  out  ADDR_WIDTH  word-aligned address driven to the RAM fetch read port.
REQ-010 ram_rdata_i  in  DATA_WIDTH  RAM word at ram_addr_o, combinational, same cycle.
REQ-011 redirect_i  in  1  branch/jump redirect strobe.
REQ-012 redirect_addr_i  in  ADDR_WIDTH  redirect target.
REQ-013 instr_valid_o  out  1  FIFO head holds a valid instruction.
REQ-014 instr_ready_i  in  1  consumer accepts the head word.
REQ-015 instr_rdata_o  out  DATA_WIDTH  head instruction word.
REQ-016 instr_addr_o  out  ADDR_WIDTH  address of the head instruction.
REQ-017 busy_o  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018 ram_addr_o shall equal pc_q at all times, with the low log2(DATA_WIDTH/8) bits forced to zero.
REQ-019 FSM states: IDLE, FETCH, FULL.
- IDLE to FETCH when fetch_en_i=1.
- FETCH to FULL when the FIFO becomes full with no pop.
- FULL to FETCH on a pop.
- FETCH or FULL to IDLE when fetch_en_i=0.
REQ-020 Push condition, in FETCH:
- Push when FIFO not full, or full with a pop in the same cycle.
- Push writes {pc_q, ram_rdata_i} into the FIFO.
- pc_q advances by DATA_WIDTH/8.
REQ-021 pc_q increment shall wrap modulo 2^ADDR_WIDTH; the increment after the top word is 0.
REQ-022 Pop occurs when instr_valid_o and instr_ready_i are both 1; the head advances on that edge.
REQ-023 Latency: the first instr_valid_o rises one cycle after the first FETCH cycle.
REQ-024 Sustained throughput shall be one instruction per cycle while instr_ready_i is held at 1.
REQ-025 instr_valid_o, instr_rdata_o and instr_addr_o shall stay stable while valid=1 and ready=0.
REQ-026 Redirect has priority over push and pop in the same cycle.
- The FIFO is flushed.
- pc_q loads redirect_addr_i with its low bits cleared.
- instr_valid_o is 0 in the next cycle.
- The first redirected instruction is valid two cycles after the redirect.
REQ-027 Redirect in IDLE shall update pc_q only; no fetch is issued until fetch_en_i=1.
REQ-028 Deasserting fetch_en_i stops pushes next cycle; FIFO contents remain poppable.
REQ-029 Pop with an empty FIFO shall have no effect; the FIFO count never underflows or overflows.

Reset
REQ-030 Reset values while rst_ni=0:
- pc_q=BOOT_ADDR.
- FSM=IDLE.
- FIFO empty.
- instr_valid_o=0, instr_rdata_o=0, instr_addr_o=0, busy_o=0.
- ram_addr_o=BOOT_ADDR.
REQ-031 Reset asserted mid-fetch shall discard all buffered entries immediately; no partial state survives.

Structure
REQ-032 A shared package fetch_pkg holds:
- The FSM state enum.
- The FIFO entry struct {addr, instr}.
REQ-033 The FIFO shall be a sub-module fetch_fifo.
- Inputs: push, pop, flush.
- Outputs: full, empty, head.
- Asynchronous active-low reset.

Verification
REQ-034 Reset, fetch_en_i=1, ready=1, RAM words 0x11,0x22,0x33 at 0,4,8 -> instr_valid_o rises cycle 1; addr/data 0/0x11, 4/0x22, 8/0x33 on consecutive cycles.
REQ-035 ready=0 for 5 cycles with FIFO_DEPTH=2 -> FSM FULL, ram_addr_o holds 0x08, head stays 0/0x11; ready=1 resumes in order, no loss or duplication.
REQ-036 redirect_i=1 with redirect_addr_i=0x41 in the same cycle as a pop -> next cycle valid=0, ram_addr_o=0x40; the cycle after, instr_addr_o=0x40.
REQ-037 Redirect to 0xFC with ready=1 -> fetch sequence 0xFC then 0x00 (wrap).
REQ-038 rst_ni pulsed low asynchronously mid-stream with 2 entries buffered -> outputs zero at once, ram_addr_o=BOOT_ADDR; no stale instruction appears after release.
REQ-039 fetch_en_i=0 with 2 entries buffered -> both entries drained, no new pushes, busy_o falls after the last pop.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and prefetch FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    // Storage widths of one prefetch entry; instr_fetch defaults its
    // ADDR_WIDTH/DATA_WIDTH to these so the FIFO entry and the ports agree.
    localparam int FETCH_ADDR_W = 8;
    localparam int FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {addr, instr} entries; head is visible combinationally.
// Latency: a pushed entry is at the head on the next cycle when the FIFO was empty.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop on empty is ignored; flush wins.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push/push_entry write side;
// pop read side; flush empties the FIFO; full/empty/level status; head is the oldest entry
// (zero while empty).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t          mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign level  = count;
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a PC through a combinational instruction RAM into a prefetch FIFO.
// Latency: first instruction valid one cycle after the first FETCH cycle; redirect target valid two cycles after redirect.
// Backpressure: instr_valid_o/instr_ready_i handshake; FIFO full with no pop stalls the PC (FULL state).
//
// Ports: clk_i/rst_ni clock and async active-low reset; fetch_en_i enables fetching;
// ram_addr_o/ram_rdata_i RAM read port; redirect_i/redirect_addr_i branch redirect;
// instr_valid_o/instr_ready_i/instr_rdata_o/instr_addr_o consumer side; busy_o activity flag.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
    parameter int                    DATA_WIDTH = FETCH_DATA_W,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_en_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  busy_o
);

    localparam int                    BYTES      = DATA_WIDTH / 8;
    localparam int                    OFF_BITS   = $clog2(BYTES);
    localparam int                    LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(BYTES);

    fetch_state_t           state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LVL_W-1:0]       fifo_level;
    fetch_entry_t           push_entry;
    fetch_entry_t           head;

    assign ram_addr_o    = pc_q & ALIGN_MASK;
    assign instr_valid_o = !fifo_empty;
    assign instr_rdata_o = DATA_WIDTH'(head.instr);
    assign instr_addr_o  = ADDR_WIDTH'(head.addr);
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;

    assign pop  = instr_valid_o && instr_ready_i;
    // Redirect flushes the FIFO, so any write in that cycle would be a wrong-path word.
    assign push = (state_q == ST_FETCH) && (!fifo_full || pop) && !redirect_i;

    assign push_entry.addr  = FETCH_ADDR_W'(ram_addr_o);
    assign push_entry.instr = FETCH_DATA_W'(ram_rdata_i);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_i),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level),
        .head       (head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= BOOT_ADDR;
        end else begin
            // Wraps naturally modulo 2^ADDR_WIDTH.
            if (redirect_i) begin
                pc_q <= redirect_addr_i & ALIGN_MASK;
            end else if (push) begin
                pc_q <= pc_q + PC_INC;
            end

            if (!fetch_en_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_FETCH;
                    ST_FETCH: begin
                        // Either this push fills the last slot, or we re-entered FETCH
                        // with a FIFO that was already full.
                        if (!redirect_i && !pop &&
                            (fifo_full || (push && fifo_level == LVL_W'(FIFO_DEPTH - 1)))) begin
                            state_q <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (redirect_i || pop) begin
                            state_q <= ST_FETCH;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a RAM model and an address scoreboard.
// Latency: n/a.
// Backpressure: bench drives instr_ready_i directly.
module tb_instr_fetch;

    logic        clk_i;
    logic        rst_ni;
    logic        fetch_en_i;
    logic [7:0]  ram_addr_o;
    logic [31:0] ram_rdata_i;
    logic        redirect_i;
    logic [7:0]  redirect_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_rdata_o;
    logic [7:0]  instr_addr_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];

    instr_fetch dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .fetch_en_i      (fetch_en_i),
        .ram_addr_o      (ram_addr_o),
        .ram_rdata_i     (ram_rdata_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_rdata_o   (instr_rdata_o),
        .instr_addr_o    (instr_addr_o),
        .busy_o          (busy_o)
    );

    // RAM contents: 0x11, 0x22, 0x33 at 0, 4, 8; address-tagged words elsewhere.
    function automatic logic [31:0] ram_word(input logic [7:0] a);
        if (a < 8'd12) return 32'((a / 4 + 1) * 32'h11);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    assign ram_rdata_i = ram_word(ram_addr_o);

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Settle inputs, score any handshake of this cycle, then advance past the next edge.
    task automatic cyc();
        logic [7:0] e;
        #1;
        if (instr_valid_o && instr_ready_i) begin
            tests++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_pop observed addr=0x%02h expected no instruction", instr_addr_o);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pop_addr", {24'h0, instr_addr_o}, {24'h0, e});
                chk("pop_data", instr_rdata_o, ram_word(e));
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},    {31'h0, instr_valid_o}, 32'h0);
        chk({tag, "_rdata"},    instr_rdata_o, 32'h0);
        chk({tag, "_iaddr"},    {24'h0, instr_addr_o}, 32'h0);
        chk({tag, "_busy"},     {31'h0, busy_o}, 32'h0);
        chk({tag, "_ram_addr"}, {24'h0, ram_addr_o}, 32'h0);
    endtask

    initial begin
        rst_ni = 1'b0; fetch_en_i = 1'b0; instr_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_addr_i = 8'h00;
        #2;
        chk_reset_outputs("reset");
        @(posedge clk_i); @(posedge clk_i); #1;

        // Streaming from boot with ready held high.
        fetch_en_i = 1'b1; instr_ready_i = 1'b1; rst_ni = 1'b1;
        q.push_back(8'h00); q.push_back(8'h04); q.push_back(8'h08);
        cyc();
        chk("a_valid_before_first", {31'h0, instr_valid_o}, 32'h0);
        chk("a_busy_fetch", {31'h0, busy_o}, 32'h1);
        cyc();
        chk("a_valid_first", {31'h0, instr_valid_o}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("a_stream_valid", {31'h0, instr_valid_o}, 32'h1);
            cyc();
        end
        chk("a_drained", q.size(), 32'd0);
        instr_ready_i = 1'b0;
        cyc();
        chk("a_head_hold", {24'h0, instr_addr_o}, 32'h0C);

        // Asynchronous reset with two entries buffered.
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        #1;
        rst_ni = 1'b1; fetch_en_i = 1'b0; instr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("midrst_no_stale", {31'h0, instr_valid_o}, 32'h0);
        end

        // Stall until FULL, then resume in order.
        fetch_en_i = 1'b1; instr_ready_i = 1'b0;
        q.push_back(8'h00); q.push_back(8'h04);
        cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            chk("b_hold_valid", {31'h0, instr_valid_o}, 32'h1);
            chk("b_hold_addr", {24'h0, instr_addr_o}, 32'h00);
            chk("b_hold_data", instr_rdata_o, 32'h11);
            cyc();
        end
        chk("b_full_ram_addr", {24'h0, ram_addr_o}, 32'h08);
        instr_ready_i = 1'b1;
        q.push_back(8'h08); q.push_back(8'h0C); q.push_back(8'h10);
        repeat (5) cyc();
        chk("b_resume_drained", q.size(), 32'd0);
        chk("b_resume_head", {24'h0, instr_addr_o}, 32'h14);

        // Redirect to 0x41 in the same cycle as a pop.
        q.push_back(8'h14);
        redirect_i = 1'b1; redirect_addr_i = 8'h41;
        cyc();
        redirect_i = 1'b0;
        chk("c_valid_off", {31'h0, instr_valid_o}, 32'h0);
        chk("c_ram_addr", {24'h0, ram_addr_o}, 32'h40);
        q.delete();
        q.push_back(8'h40);
        cyc();
        chk("c_valid_on", {31'h0, instr_valid_o}, 32'h1);
        chk("c_iaddr", {24'h0, instr_addr_o}, 32'h40);

        // Redirect to the top word; PC wraps to 0.
        redirect_i = 1'b1; redirect_addr_i = 8'hFC;
        cyc();
        redirect_i = 1'b0;
        chk("d_valid_off", {31'h0, instr_valid_o}, 32'h0);
        chk("d_ram_addr", {24'h0, ram_addr_o}, 32'hFC);
        q.delete();
        q.push_back(8'hFC); q.push_back(8'h00);
        cyc();
        chk("d_head_top", {24'h0, instr_addr_o}, 32'hFC);
        chk("d_wrap_ram_addr", {24'h0, ram_addr_o}, 32'h00);
        cyc();
        chk("d_wrap_head", {24'h0, instr_addr_o}, 32'h00);
        cyc();
        instr_ready_i = 1'b0;
        chk("d_q_empty", q.size(), 32'd0);

        // Fill, then disable fetching and drain the two buffered entries.
        cyc();
        chk("e_full_ram_addr", {24'h0, ram_addr_o}, 32'h0C);
        fetch_en_i = 1'b0;
        cyc();
        chk("e_busy_buffered", {31'h0, busy_o}, 32'h1);
        chk("e_ram_addr_hold", {24'h0, ram_addr_o}, 32'h0C);
        instr_ready_i = 1'b1;
        q.push_back(8'h04); q.push_back(8'h08);
        cyc();
        chk("e_busy_mid", {31'h0, busy_o}, 32'h1);
        cyc();
        chk("e_valid_done", {31'h0, instr_valid_o}, 32'h0);
        chk("e_busy_done", {31'h0, busy_o}, 32'h0);
        chk("e_no_push", {24'h0, ram_addr_o}, 32'h0C);
        cyc();
        chk("e_idle_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("e_q_empty", q.size(), 32'd0);

        // Redirect while idle only moves the PC.
        redirect_i = 1'b1; redirect_addr_i = 8'h82;
        cyc();
        redirect_i = 1'b0;
        chk("f_ram_addr", {24'h0, ram_addr_o}, 32'h80);
        chk("f_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("f_busy", {31'h0, busy_o}, 32'h0);
        cyc();
        chk("f_idle_valid", {31'h0, instr_valid_o}, 32'h0);
        fetch_en_i = 1'b1; instr_ready_i = 1'b0;
        cyc(); cyc();
        chk("f_valid_on", {31'h0, instr_valid_o}, 32'h1);
        chk("f_iaddr", {24'h0, instr_addr_o}, 32'h80);
        chk("f_rdata", instr_rdata_o, ram_word(8'h80));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
